// File: rtl/sort_pkg.sv
// Shared constants and types for the sort result receiver.
package sort_pkg;

  localparam int unsigned SORT_WIDTH = 32;
  localparam int unsigned SORT_DEPTH = 10;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } sort_state_e;

endpackage

// File: rtl/sort_order_check.sv
// Order checker: remembers the previous accepted word and flags a signed decrease.
// The flag is cleared by the first word of each frame, so it describes one frame.
module sort_order_check #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept_i,
  input  logic             first_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             error_o
);

  logic [WIDTH-1:0] prev_q;
  logic             error_q;

  // Track the previous word and latch any out-of-order step within the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      error_q <= 1'b0;
    end else if (accept_i) begin
      prev_q <= word_i;
      if (first_i) begin
        error_q <= 1'b0;
      end else if ($signed(word_i) < $signed(prev_q)) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error_o = error_q;

endmodule

// File: rtl/sort_result_rx.sv
// Sort result receiver: captures one frame of DEPTH signed words from the sorter,
// holds it until the host acknowledges, and offers registered random-access reads.
// Macro SORT_RX_CHECK_EN enables the order checker; without it sorted_ok_o is tied high.
module sort_result_rx
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = SORT_WIDTH,
  parameter int unsigned DEPTH = SORT_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_serial_i,
  input  logic             data_valid_i,
  output logic             ready_o,
  input  logic             frame_ack_i,
  input  logic [3:0]       rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             frame_done_o,
  output logic             full_o,
  output logic             sorted_ok_o,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(DEPTH - 1);

  sort_state_e      state_q;
  logic             ready_q;
  logic             full_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;

  logic accept;
  logic first_word;
  logic last_word;

  // ready_q is high only in RECV, so this also blocks capture while holding.
  assign accept     = data_valid_i & ready_q;
  assign first_word = (cnt_q == '0);
  assign last_word  = accept && (cnt_q == LastIdx);

  // Frame FSM with registered ready/full flags and the end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RECV;
      ready_q <= 1'b1;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RECV: begin
          if (accept) begin
            if (cnt_q == LastIdx) begin
              cnt_q   <= '0;
              state_q <= HOLD;
              ready_q <= 1'b0;
              full_q  <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // An ack wins over a coincident valid word; that word is dropped.
          if (frame_ack_i) begin
            state_q <= RECV;
            ready_q <= 1'b1;
            full_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= RECV;
          ready_q <= 1'b1;
          full_q  <= 1'b0;
        end
      endcase
    end
  end

  // Frame buffer plus first/last word copies for min/max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      min_q <= '0;
      max_q <= '0;
    end else if (accept) begin
      mem_q[cnt_q] <= data_serial_i;
      if (first_word) begin
        min_q <= data_serial_i;
      end
      if (last_word) begin
        max_q <= data_serial_i;
      end
    end
  end

  // Registered read port; indices past the frame read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (32'(rd_addr_i) < DEPTH) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

`ifdef SORT_RX_CHECK_EN
  logic order_error;

  sort_order_check #(
    .WIDTH (WIDTH)
  ) u_order_check (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept_i (accept),
    .first_i  (first_word),
    .word_i   (data_serial_i),
    .error_o  (order_error)
  );

  assign sorted_ok_o = ~order_error;
`else
  assign sorted_ok_o = 1'b1;
`endif

  assign ready_o      = ready_q;
  assign full_o       = full_q;
  assign frame_done_o = done_q;
  assign rd_data_o    = rd_data_q;
  assign min_o        = min_q;
  assign max_o        = max_q;

endmodule

// File: tb/tb_sort_result_rx.sv
// Directed bench for sort_result_rx: sorted/unsorted frames, hold, ack/valid collision,
// mid-frame reset and gapped input.
module tb_sort_result_rx;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_serial;
  logic        data_valid;
  logic        ready;
  logic        frame_ack;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        frame_done;
  logic        full;
  logic        sorted_ok;
  logic [31:0] min_v;
  logic [31:0] max_v;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_base;

  int sorted_v [10] = '{-5, -1, 0, 2, 3, 3, 7, 9, 12, 40};
  int unsort_v [10] = '{1, 2, 3, 4, 0, 5, 6, 7, 8, 9};
  int gap_v    [10] = '{-100, -50, -50, 0, 1, 1000, 2000, 2001, 30000, 65536};

`ifdef SORT_RX_CHECK_EN
  localparam logic UnsortedOk = 1'b0;
`else
  localparam logic UnsortedOk = 1'b1;
`endif

  sort_result_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_serial_i (data_serial),
    .data_valid_i  (data_valid),
    .ready_o       (ready),
    .frame_ack_i   (frame_ack),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .frame_done_o  (frame_done),
    .full_o        (full),
    .sorted_ok_o   (sorted_ok),
    .min_o         (min_v),
    .max_o         (max_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count end-of-frame pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    data_serial = v;
    data_valid  = 1'b1;
    tick();
    data_valid  = 1'b0;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic read_check(input string tag, input int exp [10]);
    for (int a = 0; a < 10; a++) begin
      rd_addr = 4'(a);
      tick();
      check($sformatf("%s[%0d]", tag, a), rd_data, exp[a]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    data_serial = '0;
    data_valid = 1'b0;
    frame_ack = 1'b0;
    rd_addr = '0;
    #12;
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_sorted_ok", {31'b0, sorted_ok}, 32'd1);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_min", min_v, 32'd0);
    check("rst_max", max_v, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Sorted frame, valid every cycle.
    done_base = done_cnt;
    for (int i = 0; i < 10; i++) begin
      data_serial = sorted_v[i];
      data_valid = 1'b1;
      tick();
      if (i == 8) check("no_early_done", {31'b0, frame_done}, 32'd0);
    end
    data_valid = 1'b0;
    check("f1_done_pulse", {31'b0, frame_done}, 32'd1);
    check("f1_full", {31'b0, full}, 32'd1);
    check("f1_ready", {31'b0, ready}, 32'd0);
    check("f1_sorted_ok", {31'b0, sorted_ok}, 32'd1);
    check("f1_min", min_v, 32'hFFFF_FFFB);
    check("f1_max", max_v, 32'd40);
    tick();
    check("f1_done_once", done_cnt - done_base, 1);
    read_check("f1_rd", sorted_v);

    // Holding: incoming valid words are ignored.
    data_serial = 99;
    data_valid = 1'b1;
    repeat (5) tick();
    data_valid = 1'b0;
    check("hold_full", {31'b0, full}, 32'd1);
    check("hold_ready", {31'b0, ready}, 32'd0);
    read_check("hold_rd", sorted_v);
    check("hold_min", min_v, 32'hFFFF_FFFB);

    // Ack coincident with a valid word: word dropped, receiver reopens.
    data_serial = 77;
    data_valid = 1'b1;
    frame_ack = 1'b1;
    tick();
    data_valid = 1'b0;
    frame_ack = 1'b0;
    check("ack_ready", {31'b0, ready}, 32'd1);
    check("ack_full", {31'b0, full}, 32'd0);

    // Unsorted frame; first word must land at index 0.
    for (int i = 0; i < 10; i++) send(unsort_v[i]);
    check("f2_full", {31'b0, full}, 32'd1);
    check("f2_sorted_ok", {31'b0, sorted_ok}, {31'b0, UnsortedOk});
    check("f2_min", min_v, 32'd1);
    check("f2_max", max_v, 32'd9);
    read_check("f2_rd", unsort_v);
    ack();

    // Ack while receiving is ignored.
    ack();
    check("ack_in_recv_ready", {31'b0, ready}, 32'd1);
    check("ack_in_recv_full", {31'b0, full}, 32'd0);

    // Sorted frame after an unsorted one clears the error.
    for (int i = 0; i < 10; i++) send(sorted_v[i]);
    check("f3_full", {31'b0, full}, 32'd1);
    check("f3_sorted_ok", {31'b0, sorted_ok}, 32'd1);
    ack();

    // Reset after four words.
    for (int i = 0; i < 4; i++) send(100 + i);
    rd_addr = 4'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_ready", {31'b0, ready}, 32'd1);
    check("mrst_full", {31'b0, full}, 32'd0);
    check("mrst_done", {31'b0, frame_done}, 32'd0);
    check("mrst_sorted_ok", {31'b0, sorted_ok}, 32'd1);
    check("mrst_rd_data", rd_data, 32'd0);
    check("mrst_min", min_v, 32'd0);
    check("mrst_max", max_v, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Gapped frame; exactly ten accepted words end it.
    done_base = done_cnt;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (i == 9) check("gap_no_early_done", done_cnt - done_base, 0);
      send(gap_v[i]);
    end
    check("gap_done_pulse", {31'b0, frame_done}, 32'd1);
    check("gap_full", {31'b0, full}, 32'd1);
    check("gap_sorted_ok", {31'b0, sorted_ok}, 32'd1);
    check("gap_min", min_v, 32'hFFFF_FF9C);
    check("gap_max", max_v, 32'd65536);
    tick();
    check("gap_done_once", done_cnt - done_base, 1);
    read_check("gap_rd", gap_v);
    rd_addr = 4'd12;
    tick();
    check("rd_oob_12", rd_data, 32'd0);
    rd_addr = 4'd10;
    tick();
    check("rd_oob_10", rd_data, 32'd0);
    rd_addr = 4'd9;
    tick();
    check("rd_last_9", rd_data, 32'd65536);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
